// File: rtl/vga_sync_receiver.sv
// VGA timing receiver: measures hsync/vsync, locks, regenerates pixel position.
// Ports: VGA_clk, reset (sync, high), VGA_hSync/VGA_vSync (active low) in;
//   xCount/yCount/displayArea, locked/lockLost, hTotal/vTotal/hSyncWidth out.
module vga_sync_receiver #(
  parameter int CW          = 11,
  parameter int H_START     = 144,
  parameter int H_ACTIVE    = 640,
  parameter int V_START     = 35,
  parameter int V_ACTIVE    = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic          VGA_clk,
  input  logic          reset,
  input  logic          VGA_hSync,
  input  logic          VGA_vSync,
  output logic [9:0]    xCount,
  output logic [9:0]    yCount,
  output logic          displayArea,
  output logic          locked,
  output logic          lockLost,
  output logic [CW-1:0] hTotal,
  output logic [CW-1:0] vTotal,
  output logic [CW-1:0] hSyncWidth
);

  typedef enum logic [1:0] {
    SEARCH,
    VERIFY,
    LOCKED
  } state_t;

  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] HS = CW'(H_START);
  localparam logic [CW-1:0] HE = CW'(H_START + H_ACTIVE);
  localparam logic [CW-1:0] VS = CW'(V_START);
  localparam logic [CW-1:0] VE = CW'(V_START + V_ACTIVE);

  state_t        state;
  logic          hs1, hs2, vs1, vs2;
  logic [CW-1:0] h_cnt;
  logic [CW-1:0] line_cnt;
  logic          line_bad;
  logic          first_frame;
  logic [3:0]    good;

  logic          h_start, h_end, v_start;
  logic          h_sat;
  logic [CW-1:0] h_inc;
  logic [CW-1:0] v_new;
  logic          line_mis, frame_mis, frame_good;
  logic [3:0]    good_inc;
  logic          lock_now, lose, locked_next;
  logic          in_h, in_v;

  always_comb begin
    h_start    = hs1 & ~hs2;
    h_end      = ~hs1 & hs2;
    v_start    = vs1 & ~vs2;
    h_inc      = h_cnt + 1'b1;
    h_sat      = (h_cnt == CNT_MAX);
    // frame length counts the line whose H-start coincides with V-start
    v_new      = line_cnt + {{(CW-1){1'b0}}, h_start};
    line_mis   = h_start && (h_inc != hTotal);
    frame_mis  = (v_new != vTotal);
    frame_good = !line_bad && (vTotal != '0) && !frame_mis;
    good_inc   = good + 4'd1;
    // the first frame after SEARCH only establishes the reference length
    lock_now   = (state == VERIFY) && !h_sat && v_start &&
                 !first_frame && frame_good &&
                 (good_inc >= 4'(LOCK_FRAMES));
    lose       = (state == LOCKED) &&
                 (line_mis || (v_start && frame_mis) || h_sat);
    locked_next = lock_now || ((state == LOCKED) && !lose);
    in_h       = (h_cnt >= HS) && (h_cnt < HE);
    in_v       = (line_cnt >= VS) && (line_cnt < VE);
  end

  always_ff @(posedge VGA_clk) begin
    if (reset) begin
      state       <= SEARCH;
      hs1         <= 1'b0;
      hs2         <= 1'b0;
      vs1         <= 1'b0;
      vs2         <= 1'b0;
      h_cnt       <= '0;
      line_cnt    <= '0;
      line_bad    <= 1'b0;
      first_frame <= 1'b0;
      good        <= '0;
      hTotal      <= '0;
      vTotal      <= '0;
      hSyncWidth  <= '0;
      xCount      <= '0;
      yCount      <= '0;
      displayArea <= 1'b0;
      locked      <= 1'b0;
      lockLost    <= 1'b0;
    end else begin
      hs1 <= ~VGA_hSync;
      hs2 <= hs1;
      vs1 <= ~VGA_vSync;
      vs2 <= vs1;

      if (h_start) begin
        h_cnt  <= '0;
        hTotal <= h_inc;
      end else if (!h_sat) begin
        h_cnt <= h_inc;
      end

      if (h_end) hSyncWidth <= h_inc;

      if (v_start) begin
        line_cnt <= '0;
        vTotal   <= v_new;
      end else if (h_start) begin
        line_cnt <= line_cnt + 1'b1;
      end

      if (v_start) line_bad <= 1'b0;
      else if (line_mis) line_bad <= 1'b1;

      xCount      <= h_cnt[9:0] - 10'(H_START);
      yCount      <= line_cnt[9:0] - 10'(V_START);
      displayArea <= locked_next && in_h && in_v;
      locked      <= locked_next;
      lockLost    <= lose;

      unique case (state)
        SEARCH: begin
          if (v_start) begin
            state       <= VERIFY;
            good        <= '0;
            first_frame <= 1'b1;
          end
        end
        VERIFY: begin
          if (h_sat) begin
            state <= SEARCH;
          end else if (v_start) begin
            first_frame <= 1'b0;
            if (lock_now) state <= LOCKED;
            else if (!first_frame && frame_good) good <= good_inc;
            else good <= '0;
          end
        end
        LOCKED: begin
          if (lose) state <= SEARCH;
        end
        default: state <= SEARCH;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Directed bench for vga_sync_receiver on a reduced 40x17 timing.
// Line: sync 8, bp 8, active 20, fp 4. Frame: sync 2, bp 3, active 10, fp 2.
module tb_vga_sync_receiver;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        hs = 1'b1;
  logic        vs = 1'b1;
  logic [9:0]  x_count, y_count;
  logic        da, lk, ll;
  logic [10:0] h_total, v_total, hs_width;

  vga_sync_receiver #(
    .CW(11), .H_START(16), .H_ACTIVE(20),
    .V_START(5), .V_ACTIVE(10), .LOCK_FRAMES(2)
  ) dut (
    .VGA_clk(clk),
    .reset(reset),
    .VGA_hSync(hs),
    .VGA_vSync(vs),
    .xCount(x_count),
    .yCount(y_count),
    .displayArea(da),
    .locked(lk),
    .lockLost(ll),
    .hTotal(h_total),
    .vTotal(v_total),
    .hSyncWidth(hs_width)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  int gh = 0, gv = 0, gf = 0;
  int line_len = 40, frame_len = 17;
  bit gen_on = 0, force_hi = 0;
  int stretch_f = -1, stretch_v = -1, long_f = -1;
  int ph, pv, pf;

  bit mon_on = 0;
  int mon_f = 0;
  int da_cnt = 0, err_da = 0, err_xy = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic drive();
    if (gen_on && !force_hi) begin
      hs = (gh >= 8);
      vs = (gv >= 2);
    end else begin
      hs = 1'b1;
      vs = 1'b1;
    end
  endtask

  task automatic advance();
    gh++;
    if (gh >= line_len) begin
      gh = 0;
      gv++;
      if (gv >= frame_len) begin
        gv = 0;
        gf++;
        frame_len = (gf == long_f) ? 18 : 17;
      end
      line_len = (gf == stretch_f && gv == stretch_v) ? 41 : 40;
    end
  endtask

  task automatic monitor();
    bit exp_da;
    exp_da = (ph >= 18 && ph < 38 && pv >= 5 && pv < 15);
    if (da !== exp_da) err_da++;
    if (da) da_cnt++;
    if (exp_da && (x_count != 10'(ph - 18) || y_count != 10'(pv - 5)))
      err_xy++;
    if (ph == 17 && pv == 5) chk("t2_da_pre", da, 0);
    if (ph == 18 && pv == 5) begin
      chk("t2_da_first", da, 1);
      chk("t2_x_first", x_count, 0);
      chk("t2_y_first", y_count, 0);
    end
    if (ph == 37 && pv == 14) begin
      chk("t2_x_last", x_count, 19);
      chk("t2_y_last", y_count, 9);
    end
    if (ph == 38 && pv == 14) chk("t2_da_post", da, 0);
  endtask

  task automatic tick();
    @(negedge clk);
    ph = gh;
    pv = gv;
    pf = gf;
    if (mon_on && pf == mon_f) monitor();
    if (gen_on) advance();
    drive();
  endtask

  task automatic gen_start();
    gh = 0;
    gv = 0;
    gf = 0;
    line_len = 40;
    frame_len = 17;
    gen_on = 1;
    drive();
  endtask

  task automatic wait_lock(input int budget, output int pos);
    pos = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (lk === 1'b1) begin
        pos = pf * 100000 + pv * 100 + ph;
        break;
      end
    end
  endtask

  task automatic wait_lost(input int budget, output int pos, output int n);
    pos = -1;
    n = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (ll === 1'b1) begin
        pos = pf * 100000 + pv * 100 + ph;
        n = i + 1;
        break;
      end
    end
  endtask

  task automatic wait_at(input int f, input int v, input int h,
                         input int budget, input string tag);
    int pos;
    pos = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (pf == f && pv == v && ph == h) begin
        pos = pf * 100000 + pv * 100 + ph;
        break;
      end
    end
    chk(tag, pos, f * 100000 + v * 100 + h);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_x"}, x_count, 0);
    chk({tag, "_y"}, y_count, 0);
    chk({tag, "_da"}, da, 0);
    chk({tag, "_lk"}, lk, 0);
    chk({tag, "_ll"}, ll, 0);
    chk({tag, "_ht"}, h_total, 0);
    chk({tag, "_vt"}, v_total, 0);
    chk({tag, "_hw"}, hs_width, 0);
  endtask

  initial begin
    int pos, n;

    reset = 1'b1;
    drive();
    repeat (3) tick();
    chk_zero("rst");

    // test 1: clean timing from reset release
    reset = 1'b0;
    gen_start();
    wait_lock(5000, pos);
    chk("t1_lock_pos", pos, 300001);
    chk("t1_htot", h_total, 40);
    chk("t1_vtot", v_total, 17);
    chk("t1_hsw", hs_width, 8);

    // test 2: one full locked frame
    stretch_f = 5;
    stretch_v = 7;
    long_f = 10;
    mon_f = 4;
    mon_on = 1;
    wait_at(5, 0, 0, 2000, "t2_reach");
    mon_on = 0;
    chk("t2_da_cnt", da_cnt, 200);
    chk("t2_da_err", err_da, 0);
    chk("t2_xy_err", err_xy, 0);

    // test 3: line 7 of frame 5 stretched to 41
    wait_lost(2000, pos, n);
    chk("t3_lost_pos", pos, 500801);
    chk("t3_lk", lk, 0);
    chk("t3_da", da, 0);
    chk("t3_htot", h_total, 41);
    tick();
    chk("t3_pulse", ll, 0);
    wait_lock(5000, pos);
    chk("t3_relock_pos", pos, 900001);

    // test 4: frame 10 has 18 lines
    wait_lost(2000, pos, n);
    chk("t4_lost_pos", pos, 1100001);
    chk("t4_vtot", v_total, 18);
    wait_lock(5000, pos);
    chk("t4_relock_pos", pos, 1500001);

    // test 5: syncs held high from mid line 3 of frame 15
    wait_at(15, 3, 20, 2000, "t5_reach");
    force_hi = 1;
    wait_lost(3000, pos, n);
    chk("t5_lost_cycles", n, 2029);
    chk("t5_lk", lk, 0);
    chk("t5_htot", h_total, 40);
    force_hi = 0;
    gen_start();
    wait_lock(5000, pos);
    chk("t5_relock_pos", pos, 300001);

    // test 6: reset pulse mid frame while locked
    wait_at(4, 7, 10, 2000, "t6_reach");
    chk("t6_lk_before", lk, 1);
    reset = 1'b1;
    tick();
    chk_zero("t6");
    reset = 1'b0;
    wait_lock(5000, pos);
    chk("t6_relock_pos", pos, 800001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
